// File: rtl/mcu_pkg.sv
// rtl/mcu_pkg.sv - shared constants and loader state encoding for the MCU slice
package mcu_pkg;

  localparam int FLASH_AW = 14;
  localparam int FLASH_DW = 16;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] ACK_DEFAULT  = 8'h06;
  localparam logic [7:0] NAK_DEFAULT  = 8'h15;

  // Loader state encoding, kept as plain constants so older tools can consume it
  typedef logic [3:0] loader_state_t;
  localparam loader_state_t ST_IDLE    = 4'd0;
  localparam loader_state_t ST_ADDR_LO = 4'd1;
  localparam loader_state_t ST_ADDR_HI = 4'd2;
  localparam loader_state_t ST_CNT_LO  = 4'd3;
  localparam loader_state_t ST_CNT_HI  = 4'd4;
  localparam loader_state_t ST_DATA_B0 = 4'd5;
  localparam loader_state_t ST_DATA_B1 = 4'd6;
  localparam loader_state_t ST_WRITE   = 4'd7;
  localparam loader_state_t ST_CSUM    = 4'd8;
  localparam loader_state_t ST_RESP    = 4'd9;

endpackage

// File: rtl/flash_loader.sv
// rtl/flash_loader.sv - UART frame parser that writes program FLASH and answers ACK/NAK
module flash_loader
  import mcu_pkg::*;
#(
  parameter int         TIMEOUT = 50000,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter logic [7:0] ACK     = ACK_DEFAULT,
  parameter logic [7:0] NAK     = NAK_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [FLASH_AW-1:0] flash_addr,
  output logic [FLASH_DW-1:0] flash_data,
  output logic                flash_wren,
  output logic                cpu_hold,
  output logic                load_ok,
  output logic                load_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  loader_state_t state;
  logic [TW-1:0] idle_cnt;
  logic [15:0]   words_left;
  logic [7:0]    csum;
  logic [7:0]    byte0;
  logic          resp_ack;
  logic          in_frame;
  logic          timed_out;

  // Frame body states, where the idle watchdog runs and bytes are summed
  always_comb begin
    in_frame  = (state != ST_IDLE) && (state != ST_RESP);
    timed_out = in_frame && !rx_valid && (idle_cnt == TW'(TIMEOUT));
  end

  // ACK acceptance is reported in the handshake cycle itself
  assign load_ok = tx_valid && tx_ready && resp_ack;

  // Frame parser, FLASH write sequencing and response handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idle_cnt   <= '0;
      words_left <= '0;
      csum       <= '0;
      byte0      <= '0;
      resp_ack   <= 1'b0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      flash_addr <= '0;
      flash_data <= '0;
      flash_wren <= 1'b0;
      cpu_hold   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      if (in_frame) begin
        if (rx_valid) idle_cnt <= '0;
        else if (!timed_out) idle_cnt <= idle_cnt + 1'b1;
        else idle_cnt <= '0;
      end

      // The checksum covers every accepted byte after SYNC; WRITE drops its byte
      if (in_frame && rx_valid && state != ST_WRITE) csum <= csum + rx_data;

      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == SYNC) begin
            state    <= ST_ADDR_LO;
            cpu_hold <= 1'b1;
            load_err <= 1'b0;
            csum     <= '0;
            idle_cnt <= '0;
          end
        end
        ST_ADDR_LO: if (rx_valid) begin
          flash_addr[7:0] <= rx_data;
          state           <= ST_ADDR_HI;
        end
        ST_ADDR_HI: if (rx_valid) begin
          flash_addr[FLASH_AW-1:8] <= rx_data[FLASH_AW-9:0];
          state                    <= ST_CNT_LO;
        end
        ST_CNT_LO: if (rx_valid) begin
          words_left[7:0] <= rx_data;
          state           <= ST_CNT_HI;
        end
        ST_CNT_HI: if (rx_valid) begin
          words_left[15:8] <= rx_data;
          state <= ({rx_data, words_left[7:0]} != 16'd0) ? ST_DATA_B0 : ST_CSUM;
        end
        ST_DATA_B0: if (rx_valid) begin
          byte0 <= rx_data;
          state <= ST_DATA_B1;
        end
        ST_DATA_B1: if (rx_valid) begin
          // First byte on the wire lands in the high half to match the fetch swap
          flash_data <= {byte0, rx_data};
          flash_wren <= 1'b1;
          state      <= ST_WRITE;
        end
        ST_WRITE: begin
          flash_wren <= 1'b0;
          flash_addr <= flash_addr + 1'b1;
          words_left <= words_left - 1'b1;
          state      <= (words_left != 16'd1) ? ST_DATA_B0 : ST_CSUM;
        end
        ST_CSUM: if (rx_valid) begin
          resp_ack <= ((csum + rx_data) == 8'h00);
          tx_data  <= ((csum + rx_data) == 8'h00) ? ACK : NAK;
          load_err <= load_err | ((csum + rx_data) != 8'h00);
          tx_valid <= 1'b1;
          state    <= ST_RESP;
        end
        ST_RESP: if (tx_ready) begin
          tx_valid <= 1'b0;
          cpu_hold <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A stalled sender aborts the frame; words already written stay written
      if (timed_out) begin
        state    <= ST_RESP;
        tx_data  <= NAK;
        tx_valid <= 1'b1;
        resp_ack <= 1'b0;
        load_err <= 1'b1;
      end
    end
  end

endmodule
